// File: rtl/midi_msg_assembler.sv
// MIDI channel-voice message assembler: turns a UART byte stream into
// {status, data1, data2} messages, tracking running status, and queues them in a small FWFT FIFO.
module midi_msg_assembler #(
  parameter int FIFO_AW             = 3,
  parameter bit PASS_REALTIME       = 1'b0,
  parameter bit NOTE_ON_ZERO_AS_OFF = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               msg_ready,
  output logic               msg_valid,
  output logic [7:0]         msg_status,
  output logic [6:0]         msg_data1,
  output logic [6:0]         msg_data2,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  input  logic               overflow_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} state_t;

  state_t       state_q, state_d;
  logic [7:0]   rs_q, rs_d;
  logic [6:0]   d1_q, d1_d;
  logic         push;
  logic [21:0]  push_msg;
  logic         one_byte;
  logic [7:0]   emit_status;

  // Program change (0xCn) and channel pressure (0xDn) carry a single data byte.
  assign one_byte = (rs_q[7:5] == 3'b110);

  // The Note On -> Note Off rewrite touches only the emitted copy; running status keeps 0x9n.
  assign emit_status = (NOTE_ON_ZERO_AS_OFF && rs_q[7:4] == 4'h9 && byte_data[6:0] == 7'd0)
                       ? {4'h8, rs_q[3:0]} : rs_q;

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    d1_d     = d1_q;
    push     = 1'b0;
    push_msg = '0;
    if (byte_valid) begin
      if (byte_data >= 8'hF8) begin
        if (PASS_REALTIME) begin
          push     = 1'b1;
          push_msg = {byte_data, 14'd0};
        end
      end else if (byte_data >= 8'hF0) begin
        rs_d    = '0;
        d1_d    = '0;
        state_d = SKIP;
      end else if (byte_data[7]) begin
        rs_d    = byte_data;
        d1_d    = '0;
        state_d = WAIT_D1;
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d = byte_data[6:0];
            if (one_byte) begin
              push     = 1'b1;
              push_msg = {rs_q, byte_data[6:0], 7'd0};
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            push     = 1'b1;
            push_msg = {emit_status, d1_q, byte_data[6:0]};
            state_d  = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rs_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      d1_q    <= d1_d;
    end
  end

  logic [21:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               pop, push_ok, drop;

  always_comb begin
    pop        = (count_q != '0) && msg_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok    = push && ((count_q != DEPTH_L) || pop);
    drop       = push && !push_ok;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_msg;
  end

  // Head fields are forced to zero while empty so stale storage never shows through.
  assign msg_valid = (count_q != '0);
  assign {msg_status, msg_data1, msg_data2} = msg_valid ? mem_q[rd_ptr_q] : 22'd0;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;

endmodule
